// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store unit: turns an EX/MEM memory op into one doubleword-aligned bus access and returns the aligned, extended load data.
// Latency: store 2 stall cycles, load 3 stall cycles minimum; the access is abandoned after TIMEOUT cycles in REQ+WAIT.
// Backpressure: holds the bus request and fields stable until bus_gnt; stalls the pipeline from request start until DONE.
module load_store_unit #(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            misaligned,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [7:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             we_q;
  logic [2:0]       func3_q;
  logic [2:0]       lane_q;
  logic [7:0]       wstrb_q;
  logic [XLEN-1:0]  load_q;

  logic             legal;
  logic             aligned;
  logic             start;
  logic             in_access;
  logic             timed_out;
  logic [7:0]       wstrb_nxt;
  logic [XLEN-1:0]  rd_shift;
  logic [XLEN-1:0]  rd_ext;

  // Loads use func3 000-110, stores 000-011; the low two bits give the access size.
  assign legal = req_we ? !func3[2] : (func3 != 3'b111);

  // Natural alignment check for the access size encoded in func3[1:0].
  always_comb begin
    aligned = 1'b1;
    case (func3[1:0])
      2'b01:   aligned = !addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      2'b11:   aligned = (addr[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // Reset is folded in so the combinational outputs read 0 while reset is held.
  assign start      = reset && (state == S_IDLE) && req_valid && legal && aligned;
  assign misaligned = reset && (state == S_IDLE) && req_valid && !(legal && aligned);
  assign in_access  = (state == S_REQ) || (state == S_WAIT);
  assign timed_out  = in_access && (tmo_cnt == CNT_MAX);

  assign stall     = start || in_access;
  assign bus_req   = (state == S_REQ) && !timed_out;
  assign bus_we    = bus_req && we_q;
  assign bus_wstrb = bus_req ? wstrb_q : 8'h00;
  assign bus_err   = timed_out;
  assign done      = (state == S_DONE);
  assign load_data = done ? load_q : '0;

  // Byte-lane strobes for the store, positioned by the low address bits.
  always_comb begin
    wstrb_nxt = 8'hFF;
    case (func3[1:0])
      2'b00:   wstrb_nxt = 8'h01 << addr[2:0];
      2'b01:   wstrb_nxt = 8'h03 << addr[2:0];
      2'b10:   wstrb_nxt = 8'h0F << addr[2:0];
      default: wstrb_nxt = 8'hFF;
    endcase
  end

  // Move the addressed bytes to the bottom and sign/zero-extend per func3.
  always_comb begin
    rd_shift = bus_rdata >> {lane_q, 3'b000};
    rd_ext   = rd_shift;
    case (func3_q)
      3'b000:  rd_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  rd_ext = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  rd_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  rd_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      3'b110:  rd_ext = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Next-state: the timeout takes priority over a grant or read data in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (timed_out)    state_nxt = S_DONE;
        else if (bus_gnt) state_nxt = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (timed_out)       state_nxt = S_DONE;
        else if (bus_rvalid) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; an asserted reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Capture the request on start, run the timeout counter, and grab read data in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      we_q      <= 1'b0;
      func3_q   <= 3'b000;
      lane_q    <= 3'b000;
      wstrb_q   <= 8'h00;
      bus_addr  <= '0;
      bus_wdata <= '0;
      load_q    <= '0;
    end else begin
      if (start) begin
        tmo_cnt   <= '0;
        we_q      <= req_we;
        func3_q   <= func3;
        lane_q    <= addr[2:0];
        wstrb_q   <= req_we ? wstrb_nxt : 8'h00;
        bus_addr  <= {addr[XLEN-1:3], 3'b000};
        bus_wdata <= wdata << {addr[2:0], 3'b000};
        load_q    <= '0;
      end else if (in_access) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if ((state == S_WAIT) && !timed_out && bus_rvalid) load_q <= rd_ext;
    end
  end

endmodule
